// File: rtl/sm_credit_ctrl_pkg.sv
// Shared definitions for the credit/payout sequencer: reel symbol codes,
// payout amounts and the one-hot controller state encoding.
package sm_credit_ctrl_pkg;

  typedef enum logic [3:0] {
    SymBlank     = 4'd0,
    SymCherry    = 4'd1,
    SymBlueberry = 4'd2,
    SymBanana    = 4'd3,
    SymGrape     = 4'd4,
    SymOrange    = 4'd5,
    SymLime      = 4'd6
  } symbol_e;

  localparam logic [3:0] SymMaxCode = 4'd6;

  localparam logic [15:0] PayCherry3    = 16'd5000;
  localparam logic [15:0] PayBlueberry3 = 16'd1000;
  localparam logic [15:0] PayBanana3    = 16'd500;
  localparam logic [15:0] PayGrape3     = 16'd100;
  localparam logic [15:0] PayOrange3    = 16'd25;
  localparam logic [15:0] PayLime3      = 16'd10;
  localparam logic [15:0] PayCherry2    = 16'd50;
  localparam logic [15:0] PayCherry1    = 16'd5;
  localparam logic [15:0] PayAnyThree   = 16'd1;

  typedef enum logic [6:0] {
    StInit     = 7'b000_0001,
    StIdle     = 7'b000_0010,
    StWait     = 7'b000_0100,
    StPayout   = 7'b000_1000,
    StRefund   = 7'b001_0000,
    StBcdStart = 7'b010_0000,
    StBcdWait  = 7'b100_0000
  } state_e;

  // Unknown codes behave exactly like an empty reel position.
  function automatic symbol_e sanitize_sym(logic [3:0] code);
    return (code > SymMaxCode) ? SymBlank : symbol_e'(code);
  endfunction

endpackage

// File: rtl/sm_credit_ctrl_if.sv
// Handshake bundle between the credit sequencer (slave) and its environment:
// lever, reel engine, BCD converter and display (master).
interface sm_credit_ctrl_if;

  logic        spin_req;
  logic        spin_grant;
  logic        result_valid;
  logic [11:0] symbols;
  logic        bcd_start;
  logic [15:0] bcd_bin;
  logic        bcd_done;
  logic [15:0] bcd_dat;
  logic [15:0] balance;
  logic [15:0] bal_bcd;
  logic [15:0] last_payout;
  logic        busy;
  logic        no_credit;

  modport master (
    output spin_req, result_valid, symbols, bcd_done, bcd_dat,
    input  spin_grant, bcd_start, bcd_bin, balance, bal_bcd, last_payout, busy, no_credit
  );

  modport slave (
    input  spin_req, result_valid, symbols, bcd_done, bcd_dat,
    output spin_grant, bcd_start, bcd_bin, balance, bal_bcd, last_payout, busy, no_credit
  );

endinterface

// File: rtl/sm_payout_lut.sv
// Combinational payout table: {reel2, reel1, reel0} symbols to credits won.
// Rows are prioritised top-down; the first matching row sets the payout.
module sm_payout_lut
  import sm_credit_ctrl_pkg::*;
(
  input  logic [11:0] symbols_i,
  output logic [15:0] payout_o
);

  symbol_e    r0, r1, r2;
  logic [1:0] n_cherry;
  logic       all_same;
  logic       none_blank;

  always_comb begin
    r0         = sanitize_sym(symbols_i[3:0]);
    r1         = sanitize_sym(symbols_i[7:4]);
    r2         = sanitize_sym(symbols_i[11:8]);
    n_cherry   = {1'b0, r0 == SymCherry} + {1'b0, r1 == SymCherry} + {1'b0, r2 == SymCherry};
    all_same   = (r0 == r1) && (r1 == r2);
    none_blank = (r0 != SymBlank) && (r1 != SymBlank) && (r2 != SymBlank);
    payout_o   = '0;

    if (all_same && none_blank) begin
      unique case (r0)
        SymCherry:    payout_o = PayCherry3;
        SymBlueberry: payout_o = PayBlueberry3;
        SymBanana:    payout_o = PayBanana3;
        SymGrape:     payout_o = PayGrape3;
        SymOrange:    payout_o = PayOrange3;
        SymLime:      payout_o = PayLime3;
        default:      payout_o = '0;
      endcase
    end else if (n_cherry >= 2'd2) begin
      payout_o = PayCherry2;
    end else if (n_cherry == 2'd1) begin
      payout_o = PayCherry1;
    end else if (none_blank) begin
      payout_o = PayAnyThree;
    end
  end

endmodule

// File: rtl/sm_credit_ctrl.sv
// Credit and payout sequencer: debits a bet, grants the spin, applies the payout
// table and requests one BCD conversion per balance update.
// Optional SM_CREDIT_FREE_PLAY_EN: no debit/refund, spins always granted.
module sm_credit_ctrl
  import sm_credit_ctrl_pkg::*;
#(
  parameter int unsigned INIT_BALANCE   = 1000,
  parameter int unsigned BET            = 1,
  parameter int unsigned MAX_BALANCE    = 9999,
  parameter int unsigned RESULT_TIMEOUT = 1048575
) (
  input  logic          clk,
  input  logic          rst_n,
  sm_credit_ctrl_if.slave bus_io
);

  localparam int unsigned TW       = $clog2(RESULT_TIMEOUT + 1);
  localparam logic [15:0] BetW     = 16'(BET);
  localparam logic [15:0] InitBal  = 16'(INIT_BALANCE);
  localparam logic [16:0] MaxBal   = 17'(MAX_BALANCE);
  localparam logic [TW-1:0] TimeoutW = TW'(RESULT_TIMEOUT);

`ifdef SM_CREDIT_FREE_PLAY_EN
  localparam bit FreePlay = 1'b1;
`else
  localparam bit FreePlay = 1'b0;
`endif

  // Amount taken per spin and returned on a timed-out spin.
  localparam logic [15:0] Debit = FreePlay ? 16'd0 : BetW;

  state_e        state_q;
  logic [15:0]   balance_q;
  logic [15:0]   bal_bcd_q;
  logic [15:0]   last_payout_q;
  logic          spin_grant_q;
  logic          bcd_start_q;
  logic [15:0]   bcd_bin_q;
  logic [11:0]   sym_q;
  logic [TW-1:0] cnt_q;

  logic [15:0] payout;
  logic [15:0] add_amt;
  logic [16:0] sum;
  logic [15:0] credit_bal;
  logic        can_spin;

  sm_payout_lut u_payout_lut (
    .symbols_i (sym_q),
    .payout_o  (payout)
  );

  always_comb begin
    add_amt    = (state_q == StPayout) ? payout : Debit;
    sum        = {1'b0, balance_q} + {1'b0, add_amt};
    credit_bal = (sum > MaxBal) ? MaxBal[15:0] : sum[15:0];
    can_spin   = FreePlay || (balance_q >= BetW);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StInit;
      balance_q     <= InitBal;
      bal_bcd_q     <= '0;
      last_payout_q <= '0;
      spin_grant_q  <= 1'b0;
      bcd_start_q   <= 1'b0;
      bcd_bin_q     <= '0;
      sym_q         <= '0;
      cnt_q         <= '0;
    end else begin
      spin_grant_q <= 1'b0;
      bcd_start_q  <= 1'b0;
      unique case (state_q)
        StInit: begin
          bcd_start_q <= 1'b1;
          bcd_bin_q   <= balance_q;
          state_q     <= StBcdStart;
        end
        StIdle: begin
          if (bus_io.spin_req && can_spin) begin
            balance_q    <= balance_q - Debit;
            spin_grant_q <= 1'b1;
            cnt_q        <= '0;
            state_q      <= StWait;
          end
        end
        StWait: begin
          // A result arriving on the expiry cycle still counts.
          if (bus_io.result_valid) begin
            sym_q   <= bus_io.symbols;
            state_q <= StPayout;
          end else if (cnt_q == TimeoutW) begin
            state_q <= StRefund;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        StPayout: begin
          balance_q     <= credit_bal;
          last_payout_q <= payout;
          bcd_start_q   <= 1'b1;
          bcd_bin_q     <= credit_bal;
          state_q       <= StBcdStart;
        end
        StRefund: begin
          balance_q     <= credit_bal;
          last_payout_q <= '0;
          bcd_start_q   <= 1'b1;
          bcd_bin_q     <= credit_bal;
          state_q       <= StBcdStart;
        end
        StBcdStart: begin
          state_q <= StBcdWait;
        end
        StBcdWait: begin
          if (bus_io.bcd_done) begin
            bal_bcd_q <= bus_io.bcd_dat;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign bus_io.spin_grant  = spin_grant_q;
  assign bus_io.bcd_start   = bcd_start_q;
  assign bus_io.bcd_bin     = bcd_bin_q;
  assign bus_io.balance     = balance_q;
  assign bus_io.bal_bcd     = bal_bcd_q;
  assign bus_io.last_payout = last_payout_q;
  assign bus_io.busy        = (state_q != StIdle);
`ifdef SM_CREDIT_FREE_PLAY_EN
  assign bus_io.no_credit   = 1'b0;
`else
  assign bus_io.no_credit   = (balance_q < BetW);
`endif

endmodule

// File: tb/tb_sm_credit_ctrl.sv
// Scoreboard bench for sm_credit_ctrl: stimulus pushes expected grant/conversion
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_sm_credit_ctrl;

  localparam int unsigned Timeout = 20;
`ifdef SM_CREDIT_FREE_PLAY_EN
  localparam bit FreePlay = 1'b1;
`else
  localparam bit FreePlay = 1'b0;
`endif
  localparam int Debit = FreePlay ? 0 : 1;

  typedef struct {
    bit is_bcd;
    int cyc;      // -1: cycle not checked
    int bin;
    int bal;
    int pay;
  } exp_t;

  typedef struct {
    logic [11:0] sym;
    int          pay;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   exp_bal = 1000;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sm_credit_ctrl_if bus ();
  sm_credit_ctrl_if bus_lo ();

  sm_credit_ctrl #(
    .INIT_BALANCE   (1000),
    .BET            (1),
    .MAX_BALANCE    (9999),
    .RESULT_TIMEOUT (Timeout)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  sm_credit_ctrl #(
    .INIT_BALANCE   (1),
    .BET            (1),
    .MAX_BALANCE    (9999),
    .RESULT_TIMEOUT (Timeout)
  ) u_dut_lo (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus_lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int clamp(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  // Monitor: every grant or conversion start must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bus.spin_grant || bus.bcd_start)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got grant=%0b start=%0b required none",
                 bus.spin_grant, bus.bcd_start);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", 32'(bus.bcd_start), 32'(e.is_bcd));
        if (e.cyc >= 0) chk("event_cycle", cyc, e.cyc);
        chk("event_balance", 32'(bus.balance), e.bal);
        if (e.is_bcd) begin
          chk("bcd_bin", 32'(bus.bcd_bin), e.bin);
          chk("last_payout", 32'(bus.last_payout), e.pay);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (bus.bcd_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("bcd_start_seen", 32'(ok), 32'd1);
  endtask

  task automatic send_done(input logic [15:0] dat);
    bus.bcd_done = 1'b1;
    bus.bcd_dat  = dat;
    tick();
    bus.bcd_done = 1'b0;
    chk("bal_bcd", 32'(bus.bal_bcd), 32'(dat));
    chk("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic finish_conv(input int limit);
    wait_start(limit);
    tick();
    send_done(to_bcd(exp_bal));
  endtask

  task automatic spin_and_result(input logic [11:0] sym, input int pay);
    exp_bal -= Debit;
    exp_q.push_back('{is_bcd: 1'b0, cyc: cyc + 1, bin: 0, bal: exp_bal, pay: 0});
    bus.spin_req = 1'b1;
    tick();
    bus.spin_req = 1'b0;
    tick();
    exp_bal = clamp(exp_bal + pay);
    exp_q.push_back('{is_bcd: 1'b1, cyc: cyc + 2, bin: exp_bal, bal: exp_bal, pay: pay});
    bus.result_valid = 1'b1;
    bus.symbols      = sym;
    tick();
    bus.result_valid = 1'b0;
  endtask

  vec_t vecs[9] = '{
    '{12'h111, 5000},   // 3x cherry
    '{12'h101, 50},     // two cherries
    '{12'h234, 1},      // three non-blank, no cherry
    '{12'h023, 0},      // a blank reel
    '{12'h333, 500},    // 3x banana
    '{12'h111, 5000},   // clamps at 9999
    '{12'hFFF, 0},      // out-of-range codes act as blank
    '{12'h7A1, 5},      // one cherry among invalid codes
    '{12'h222, 1000}    // 3x blueberry, clamps
  };

  initial begin
    bus.spin_req = 1'b0;    bus.result_valid = 1'b0; bus.symbols = '0;
    bus.bcd_done = 1'b0;    bus.bcd_dat = '0;
    bus_lo.spin_req = 1'b0; bus_lo.result_valid = 1'b0; bus_lo.symbols = '0;
    bus_lo.bcd_done = 1'b0; bus_lo.bcd_dat = '0;
    repeat (3) tick();

    chk("rst_balance", 32'(bus.balance), 32'd1000);
    chk("rst_bal_bcd", 32'(bus.bal_bcd), 32'd0);
    chk("rst_last_payout", 32'(bus.last_payout), 32'd0);
    chk("rst_spin_grant", 32'(bus.spin_grant), 32'd0);
    chk("rst_bcd_start", 32'(bus.bcd_start), 32'd0);
    chk("rst_bcd_bin", 32'(bus.bcd_bin), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_no_credit", 32'(bus.no_credit), 32'd0);

    // Reset release: automatic first conversion of the initial balance.
    rst_n = 1'b1;
    exp_q.push_back('{is_bcd: 1'b1, cyc: cyc + 1, bin: 1000, bal: 1000, pay: 0});
    wait_start(10);
    tick();
    // Lever pulled while a conversion is pending must be dropped.
    bus.spin_req = 1'b1;
    tick();
    bus.spin_req = 1'b0;
    tick();
    chk("busy_spin_dropped", 32'(bus.balance), 32'd1000);
    send_done(16'h1000);

    chk("lo_rst_bcd_bin", 32'(bus_lo.bcd_bin), 32'd1);
    bus_lo.bcd_done = 1'b1; bus_lo.bcd_dat = 16'h0001;
    tick();
    bus_lo.bcd_done = 1'b0;
    chk("lo_no_credit_init", 32'(bus_lo.no_credit), 32'd0);

    foreach (vecs[i]) begin
      spin_and_result(vecs[i].sym, vecs[i].pay);
      finish_conv(10);
      chk("idle_balance", 32'(bus.balance), exp_bal);
    end

    // No result: bet refunded and a conversion issued anyway.
    exp_bal -= Debit;
    exp_q.push_back('{is_bcd: 1'b0, cyc: cyc + 1, bin: 0, bal: exp_bal, pay: 0});
    bus.spin_req = 1'b1;
    tick();
    bus.spin_req = 1'b0;
    exp_bal += Debit;
    exp_q.push_back('{is_bcd: 1'b1, cyc: -1, bin: exp_bal, bal: exp_bal, pay: 0});
    finish_conv(Timeout + 10);

    // Low-balance instance: last credit spent, then lever ignored.
    bus_lo.spin_req = 1'b1;
    tick();
    bus_lo.spin_req = 1'b0;
    chk("lo_grant", 32'(bus_lo.spin_grant), 32'd1);
    tick();
    bus_lo.result_valid = 1'b1; bus_lo.symbols = 12'h000;
    tick();
    bus_lo.result_valid = 1'b0;
    for (int i = 0; i < 10 && !bus_lo.bcd_start; i++) tick();
    chk("lo_bcd_start", 32'(bus_lo.bcd_start), 32'd1);
    tick();
    bus_lo.bcd_done = 1'b1; bus_lo.bcd_dat = to_bcd(1 - Debit);
    tick();
    bus_lo.bcd_done = 1'b0;
    chk("lo_balance", 32'(bus_lo.balance), 32'(1 - Debit));
    chk("lo_no_credit", 32'(bus_lo.no_credit), 32'(!FreePlay));
    bus_lo.spin_req = 1'b1;
    tick();
    bus_lo.spin_req = 1'b0;
    chk("lo_grant_broke", 32'(bus_lo.spin_grant), 32'(FreePlay));
    chk("lo_busy_broke", 32'(bus_lo.busy), 32'(FreePlay));

    // Reset while waiting on the converter; a late done must be ignored.
    spin_and_result(12'h111, 5000);
    wait_start(10);
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    chk("midrst_balance", 32'(bus.balance), 32'd1000);
    chk("midrst_bal_bcd", 32'(bus.bal_bcd), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b1;
    exp_bal = 1000;
    exp_q.push_back('{is_bcd: 1'b1, cyc: cyc + 1, bin: 1000, bal: 1000, pay: 0});
    bus.bcd_done = 1'b1; bus.bcd_dat = 16'h7777;
    tick();
    bus.bcd_done = 1'b0;
    chk("late_done_ignored", 32'(bus.bal_bcd), 32'd0);
    finish_conv(10);

    tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
